// File: rtl/jstk_spi_reader_if.sv
// SPI bus between the joystick poller (master) and the PmodJSTK (slave).
// Framing: ss is active low; mode 0, so data changes while sclk is low and is sampled on the high phase.
interface jstk_spi_reader_if;
   logic sclk;
   logic mosi;
   logic ss;
   logic miso;

   modport master (output sclk, output mosi, output ss, input miso);
   modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/jstk_spi_reader.sv
// Periodic PmodJSTK poller: reads a 5-byte SPI frame and publishes X/Y/buttons
// atomically once the whole frame is in. CLK_DIV must be at least 2.
module jstk_spi_reader #(
   parameter int CLK_DIV     = 60,
   parameter int SS_SETUP    = 1500,
   parameter int BYTE_GAP    = 1000,
   parameter int POLL_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   jstk_spi_reader_if.master spi,
   input  logic [1:0]        leds_i,
   output logic [10:0]       x_val_o,
   output logic [10:0]       y_val_o,
   output logic [2:0]        btn_o,
   output logic              data_valid_o,
   output logic [2:0]        state_o
);
   localparam int MAX_A   = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
   localparam int MAX_B   = (BYTE_GAP > POLL_CYCLES) ? BYTE_GAP : POLL_CYCLES;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       bit_q;
   logic [2:0]       byte_q;
   logic             high_q;
   logic             miso_meta_q;
   logic             miso_sync_q;
   logic             sclk_q;
   logic             mosi_q;
   logic             ss_q;
   logic [7:0]       tx_q;
   logic [38:0]      rx_q;
   logic [10:0]      x_q;
   logic [10:0]      y_q;
   logic [2:0]       btn_q;
   logic             dv_q;

   assign cnt_d = cnt_q + 1'b1;

   // Shadow holds the first 39 bits; the 40th is the synchronized miso sampled on the publishing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         high_q      <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         ss_q        <= 1'b1;
         tx_q        <= '0;
         rx_q        <= '0;
         x_q         <= 11'd512;
         y_q         <= 11'd512;
         btn_q       <= '0;
         dv_q        <= 1'b0;
      end else begin
         miso_meta_q <= spi.miso;
         miso_sync_q <= miso_meta_q;
         dv_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cnt_q == POLL_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_SETUP;
                  ss_q    <= 1'b0;
                  tx_q    <= {6'b100000, leds_i};
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_SHIFT;
                  bit_q   <= '0;
                  high_q  <= 1'b0;
                  mosi_q  <= tx_q[7];
                  tx_q    <= {tx_q[6:0], 1'b0};
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_SHIFT: begin
               if (cnt_q != HALF_LAST) begin
                  cnt_q <= cnt_d;
               end else if (!high_q) begin
                  cnt_q  <= '0;
                  high_q <= 1'b1;
                  sclk_q <= 1'b1;
               end else begin
                  cnt_q  <= '0;
                  high_q <= 1'b0;
                  sclk_q <= 1'b0;
                  rx_q   <= {rx_q[37:0], miso_sync_q};
                  if (bit_q != 3'd7) begin
                     bit_q  <= bit_q + 3'd1;
                     mosi_q <= tx_q[7];
                     tx_q   <= {tx_q[6:0], 1'b0};
                  end else begin
                     bit_q  <= '0;
                     mosi_q <= 1'b0;
                     if (byte_q == 3'd4) begin
                        byte_q  <= '0;
                        state_q <= S_DONE;
                        ss_q    <= 1'b1;
                        dv_q    <= 1'b1;
                        x_q     <= {1'b0, rx_q[24:23], rx_q[38:31]};
                        y_q     <= {1'b0, rx_q[8:7], rx_q[22:15]};
                        btn_q   <= {rx_q[1:0], miso_sync_q};
                     end else begin
                        byte_q  <= byte_q + 3'd1;
                        state_q <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_SHIFT;
                  high_q  <= 1'b0;
                  mosi_q  <= tx_q[7];
                  tx_q    <= {tx_q[6:0], 1'b0};
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign spi.sclk     = sclk_q;
   assign spi.mosi     = mosi_q;
   assign spi.ss       = ss_q;
   assign x_val_o      = x_q;
   assign y_val_o      = y_q;
   assign btn_o        = btn_q;
   assign data_valid_o = dv_q;
   assign state_o      = state_q;
endmodule

// File: doc/jstk_spi_reader.md
# jstk_spi_reader

SPI mode-0 master that periodically polls the PmodJSTK joystick and publishes the latest X/Y position and button state as registered 11-bit values. It sits directly upstream of the servo steering stage, whose `y_val` input is driven from this block's `y_val`. On a Basys3 at 100 MHz, the defaults give an SCLK of about 833 kHz and a 10 ms poll period. The block holds its outputs between updates, so downstream PWM logic always sees a stable value.

## Interface
- `CLK_DIV`, 60: clk cycles per SCLK half-period; must be ≥ 2.
- `SS_SETUP`, 1500: cycles SS is low before the first SCLK low phase begins.
- `BYTE_GAP`, 1000: cycles SCLK is held low between consecutive bytes.
- `POLL_CYCLES`, 1_000_000: idle cycles between the end of one transaction and the next SS fall.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `miso` in 1: serial data from the joystick; asynchronous.
- `leds` in 2: LED command, sampled at SS fall.
- `sclk` out 1: SPI clock; idles low.
- `mosi` out 1: SPI data to the joystick.
- `ss` out 1: active-low slave select.
- `x_val` out 11: X position, 0..1023.
- `y_val` out 11: Y position, 0..1023.
- `btn` out 3: buttons {btn2, btn1, stick}.
- `data_valid` out 1: one-cycle pulse when new values are published.

## Operation
- `miso` passes through a 2-flop synchronizer before any use.
- State machine has five states: IDLE, SETUP, SHIFT, GAP, DONE.
- **IDLE:** `ss`=1 and `sclk`=0. The poll counter runs POLL_CYCLES cycles, then the block moves to SETUP. On that same edge `ss` falls and `leds` is captured.
- **SETUP:** lasts SS_SETUP cycles, then the block moves to SHIFT.
- **SHIFT:** clocks out 8 bits, MSB first.
  - Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - `mosi` is updated on the first cycle of each low phase.
  - The synchronized `miso` is sampled on the last cycle of each high phase, then `sclk` falls.
- **Byte sequencing:** after bytes 0–3 the block goes to GAP; after byte 4 it goes to DONE.
- **GAP:** lasts BYTE_GAP cycles with `sclk`=0, then returns to SHIFT for the next byte.
- **MOSI bytes:** byte 0 = {6'b100000, leds_captured}. Bytes 1–4 = 8'h00. `mosi`=0 outside SHIFT.
- **MISO bytes:** b0 = X[7:0], b1 = X[9:8] in bits [1:0], b2 = Y[7:0], b3 = Y[9:8], b4 = buttons in bits [2:0].
  - Unused bits of b1, b3 and b4 are ignored.
- **DONE:** lasts one cycle.
  - `ss` returns to 1.
  - `x_val`, `y_val` and `btn` update together on this edge, with `x_val` = {1'b0, b1[1:0], b0} and `y_val` = {1'b0, b3[1:0], b2}.
  - `data_valid`=1 for this cycle only.
  - The poll counter restarts and the block returns to IDLE.
- Received bytes go into a 40-bit shadow register. Outputs never show a partially received frame.
- **Reset values:**
  - `ss`=1, `sclk`=0, `mosi`=0, `data_valid`=0, `btn`=0.
  - `x_val`=`y_val`=11'd512 (stick centred, so the servo stays centred until the first frame).
  - State=IDLE and all counters = 0.
- **Reset mid-transaction:** on the next edge the transfer is abandoned and every output returns to its reset value. The partial frame is discarded and never published. After reset is released, the first SS fall occurs POLL_CYCLES cycles later.
- **`leds` changes during a transaction:** no effect until the next SS fall.
- **`miso` behaviour while `ss`=1:** ignored.

## Timing
- SS fall to first `sclk` rise = SS_SETUP + CLK_DIV cycles.
- Byte duration = 16·CLK_DIV cycles.
- Total SS-low time = SS_SETUP + 80·CLK_DIV + 4·BYTE_GAP cycles, ending at the DONE edge.
- Last `sclk` fall, `ss` rise, output update and the `data_valid` pulse all occur on the same edge.
- Transaction period = SS-low time + POLL_CYCLES + 1.
- `sclk`, `mosi` and `ss` are registered outputs and glitch-free.

## Test plan
Unless noted, tests use CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_CYCLES=20.

- **Reset state:** hold `rst` for 5 cycles. Expect `ss`=1, `sclk`=0, `x_val`=`y_val`=512, `btn`=0, `data_valid`=0. The first `ss` fall comes exactly 20 cycles after `rst` deasserts.
- **Frame decode:** a mode-0 slave model returns 0x34, 0x02, 0xFF, 0x03, 0x05. Expect `x_val`=564, `y_val`=1023, `btn`=3'b101, one `data_valid` pulse, and `ss` low for 176 cycles.
- **MOSI and LED capture:** set `leds`=2'b11, then change it to 2'b00 mid-frame. Expect the MOSI stream 0x83, 0x00, 0x00, 0x00, 0x00. The next frame must send 0x80.
- **Masking and edge values:** slave returns 0x00, 0xFC, 0x00, 0xFC, 0xF8. Expect `x_val`=0, `y_val`=0, `btn`=0, showing the ignored upper bits are masked.
- **Reset mid-frame:** assert `rst` during byte 2 after a previous good frame. Expect `ss`=1 next cycle, outputs back to 512/512/0, and no `data_valid` pulse. The next complete frame publishes correctly.
- **Clocking:** measure SCLK with default parameters. Expect a period of 120 clk cycles, duty 50%, exactly 40 rising edges per frame, and frames repeating every POLL_CYCLES + SS-low + 1 cycles.
